// File: rtl/mem_store_monitor.sv
// mem_store_monitor: watches the processor's data-memory write bus and
// latches a sticky pass / fail / timeout verdict, counting run cycles and
// stores and capturing the first illegal store.
//
// Bus semantics: MemWrite is a qualifying strobe. A store is "seen" on every
// rising edge where MemWrite=1; DataAdr/WriteData are only meaningful then.
// There is no backpressure, so the monitor never stalls the processor.
module mem_store_monitor #(
  parameter logic [31:0] PASS_ADR    = 32'd100,
  parameter logic [31:0] PASS_DATA   = 32'd7,
  parameter logic [31:0] SCRATCH_ADR = 32'd96,
  parameter logic [31:0] TIMEOUT     = 32'd1000,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] store_count,
  output logic [31:0]      cycle_count,
  output logic [31:0]      bad_adr,
  output logic [31:0]      bad_data,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TMO  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next;
  logic             w_is_pass;
  logic             w_is_scratch;
  logic             w_capture;
  logic             r_pass;
  logic             r_fail;
  logic             r_timeout;
  logic [CNT_W-1:0] r_store_count;
  logic [31:0]      r_cycle_count;
  logic [31:0]      r_bad_adr;
  logic [31:0]      r_bad_data;

  // Store classification: full 32-bit compares, no byte masking.
  always_comb begin
    w_is_pass    = (DataAdr == PASS_ADR) && (WriteData == PASS_DATA);
    w_is_scratch = (DataAdr == SCRATCH_ADR);
  end

  // Next-state: a store on the timeout edge is classified first, so a pass
  // or illegal store beats the timeout; a scratch store still times out.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    if (r_state == ST_RUN) begin
      if (MemWrite && w_is_pass) begin
        w_next = ST_PASS;
      end else if (MemWrite && !w_is_scratch) begin
        w_next    = ST_FAIL;
        w_capture = 1'b1;
      end else if (r_cycle_count == TIMEOUT - 32'd1) begin
        w_next = ST_TMO;
      end
    end
  end

  // State register; terminal states hold until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Registered verdict flags, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_pass    <= (w_next == ST_PASS);
      r_fail    <= (w_next == ST_FAIL);
      r_timeout <= (w_next == ST_TMO);
    end
  end

  // Run counters: advance only in RUN (including the verdict edge), then freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= '0;
      r_store_count <= '0;
    end else if (r_state == ST_RUN) begin
      r_cycle_count <= r_cycle_count + 32'd1;
      if (MemWrite && (r_store_count != CNT_MAX)) begin
        r_store_count <= r_store_count + 1'b1;
      end
    end
  end

  // Capture the first illegal store; held afterwards because FAIL is terminal.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bad_adr  <= '0;
      r_bad_data <= '0;
    end else if (w_capture) begin
      r_bad_adr  <= DataAdr;
      r_bad_data <= WriteData;
    end
  end

  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign done        = r_pass | r_fail | r_timeout;
  assign store_count = r_store_count;
  assign cycle_count = r_cycle_count;
  assign bad_adr     = r_bad_adr;
  assign bad_data    = r_bad_data;
  assign o_dbg_state = r_state;

endmodule

// File: doc/mem_store_monitor.md
Name: mem_store_monitor

Overview:
- Synthesizable watcher that sits directly downstream of the processor top level and consumes its data-memory write bus (MemWrite, DataAdr, WriteData).
- Classifies every store as the pass store, an allowed scratch store, or an illegal store.
- Tracks cycles and stores, and latches a sticky verdict with the offending store captured.
- Replaces ad-hoc bench checking, so the same pass/fail logic runs in simulation and on FPGA (verdict drives LEDs).

Parameters:
- PASS_ADR, 32'd100, address that marks success when written with PASS_DATA.
- PASS_DATA, 32'd7, data value required at PASS_ADR.
- SCRATCH_ADR, 32'd96, address that may be written any number of times without verdict.
- TIMEOUT, 32'd1000, run cycles allowed before declaring timeout; must be ≥1.
- CNT_W, 16, width of store_count (saturating).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; same reset as the processor.
- MemWrite  input  1  store strobe from processor.
- DataAdr  input  32  store address.
- WriteData  input  32  store data.
- done  output  1  verdict reached (pass | fail | timeout).
- pass  output  1  pass store observed.
- fail  output  1  illegal store observed.
- timeout  output  1  TIMEOUT cycles elapsed with no verdict.
- store_count  output  CNT_W  number of stores seen while in RUN, saturating at all-ones.
- cycle_count  output  32  RUN cycles elapsed.
- bad_adr  output  32  DataAdr of the first illegal store.
- bad_data  output  32  WriteData of the first illegal store.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset. On any rising edge with reset=1 (including mid-run or after a verdict):
  - state=RUN.
  - All outputs 0.
  - Counters 0; bad_adr and bad_data 0.
- States: RUN, PASS, FAIL, TMO. PASS, FAIL and TMO are terminal and sticky until reset.
- In RUN, each rising edge with reset=0:
  - cycle_count += 1.
  - If MemWrite=1:
    - store_count += 1, saturating.
    - If DataAdr==PASS_ADR and WriteData==PASS_DATA: go to PASS.
    - Else if DataAdr==SCRATCH_ADR: stay in RUN. Scratch stores with any data are legal.
    - Otherwise: go to FAIL, capturing bad_adr=DataAdr and bad_data=WriteData. This includes a write to PASS_ADR with wrong data.
  - Else if cycle_count==TIMEOUT-1: go to TMO. Timeout is declared on the edge where cycle_count would become TIMEOUT.
- Priority: a store on the timeout edge is classified first. PASS or FAIL wins over TMO; a scratch store on that edge still yields TMO.
- Outputs and latency:
  - All outputs are registered, so the verdict is visible on the cycle after the sampling edge.
  - done = pass|fail|timeout; at most one of pass/fail/timeout is ever 1.
- Terminal states:
  - cycle_count and store_count freeze.
  - MemWrite is ignored.
  - bad_adr and bad_data hold.
- MemWrite=0 never changes counters other than cycle_count, regardless of DataAdr or WriteData values.
- Comparison is full 32-bit equality with no byte masking.

Test Plan:
- Reset held 3 cycles, then store (96, 5), then (100, 7) two cycles later -> pass=1, done=1, store_count=2, fail=0; outputs unchanged for 20 further stores.
- Store (100, 6) -> fail=1, bad_adr=100, bad_data=6, pass stays 0; a later (100, 7) leaves pass=0.
- Store (200, 0xDEADBEEF) after 10 idle cycles -> fail=1, bad_adr=200, bad_data=0xDEADBEEF, cycle_count=11.
- TIMEOUT=8, no stores -> timeout=1 visible after the 8th run edge, cycle_count=8; with TIMEOUT=8 and store (100, 7) on edge 8 -> pass=1, timeout=0.
- Drive fail, then assert reset for 1 cycle -> all outputs 0, state RUN; the following (100, 7) gives pass=1.
- CNT_W=4, 20 scratch stores -> store_count saturates at 15, no verdict.
